// File: rtl/ysyx_25010008_axi_pkg.sv
// Shared AXI4-Lite response codes, FSM state encoding and counter sizing
// for the LSU-facing SRAM slave.
package ysyx_25010008_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_R_WAIT = 3'd1,
    ST_R_RESP = 3'd2,
    ST_W_DATA = 3'd3,
    ST_W_WAIT = 3'd4,
    ST_W_RESP = 3'd5
  } state_e;

  // Bit shift that moves a byte lane offset to/from bit 0.
  function automatic logic [4:0] lane_bits(input logic [1:0] byte_off);
    return {byte_off, 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_25010008_axil_sram_if.sv
// AXI4-Lite AR/R/AW/W/B channel bundle between the LSU (master) and the SRAM slave.
interface ysyx_25010008_axil_sram_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_25010008_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise response latency.
module ysyx_25010008_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/ysyx_25010008_axil_sram.sv
// AXI4-Lite single-port SRAM slave for the LSU: one transaction in flight,
// right-aligned load data, fixed or LFSR-randomised response latency.
module ysyx_25010008_axil_sram
  import ysyx_25010008_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          MEM_WORDS  = 4096,
  parameter int          RAND_DELAY = 0,
  parameter int          FIX_LAT    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  ysyx_25010008_axil_sram_if.slave  bus
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               arready_q, arready_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               rvalid_q, rvalid_d;
  logic               bvalid_q, bvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [1:0]         bresp_q, bresp_d;

  logic [7:0]         lfsr_val;
  logic               unused_lfsr_hi;
  logic [CNT_W-1:0]   lat;
  logic [31:0]        off;
  logic               in_range;
  logic [AW-1:0]      idx;
  logic [31:0]        rd_word;
  logic [3:0]         wmask;
  logic [31:0]        wdata_sh;
  logic               mem_we;

  ysyx_25010008_lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .out   (lfsr_val)
  );

  assign unused_lfsr_hi = ^lfsr_val[7:4];
  assign lat = (RAND_DELAY != 0) ? CNT_W'(lfsr_val[3:0]) : CNT_W'(FIX_LAT);

  // One address register serves both directions since only one access is in flight.
  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (off < SPAN);
  assign idx      = off[AW+1:2];
  assign wmask    = wstrb_q << off[1:0];
  assign wdata_sh = wdata_q << lane_bits(off[1:0]);

  // Byte-lane arrays so each lane maps onto its own RAM with a plain write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];

      always_ff @(posedge clock) begin
        if (!reset && mem_we && wmask[gi]) begin
          lane_mem[idx] <= wdata_sh[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[idx];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    arready_d = arready_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    rvalid_d  = rvalid_q;
    bvalid_d  = bvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.arvalid) begin
          addr_d    = bus.araddr;
          arready_d = 1'b0;
          awready_d = 1'b0;
          cnt_d     = lat;
          state_d   = ST_R_WAIT;
        end else if (bus.awvalid) begin
          addr_d    = bus.awaddr;
          arready_d = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = ST_W_DATA;
        end
      end
      ST_R_WAIT: begin
        if (cnt_q == '0) begin
          rvalid_d = 1'b1;
          rresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
          rdata_d  = in_range ? (rd_word >> lane_bits(off[1:0])) : 32'h0;
          state_d  = ST_R_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_R_RESP: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_W_DATA: begin
        if (bus.wvalid) begin
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
          wready_d = 1'b0;
          cnt_d    = lat;
          state_d  = ST_W_WAIT;
        end
      end
      ST_W_WAIT: begin
        if (cnt_q == '0) begin
          mem_we   = in_range;
          bvalid_d = 1'b1;
          bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
          state_d  = ST_W_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_W_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          arready_d = 1'b1;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b1;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bus.arready = arready_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule
